// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter for a shared combinational ALU with a one-entry response buffer per
// requester. Round-robin on contention, single-cycle accept-to-response latency.
module alu_share_arbiter #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_ALUinput,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_ALUinput,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,

  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,

  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp0_zero,

  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic            rsp1_zero
);

  localparam logic [3:0] CtrlAdd = 4'b0010;

  logic            elig0, elig1;
  logic            gnt0, gnt1;
  logic            last_grant_q, last_grant_d;
  logic            rsp0_valid_q, rsp0_valid_d;
  logic [XLEN-1:0] rsp0_result_q, rsp0_result_d;
  logic            rsp0_zero_q, rsp0_zero_d;
  logic            rsp1_valid_q, rsp1_valid_d;
  logic [XLEN-1:0] rsp1_result_q, rsp1_result_d;
  logic            rsp1_zero_q, rsp1_zero_d;

  // A requester may issue only if its buffer is free or being drained this cycle.
  // Gating with rst_n keeps the handshake dead while reset is held.
  always_comb begin
    elig0 = rst_n & req0_valid & (~rsp0_valid_q | rsp0_ready);
    elig1 = rst_n & req1_valid & (~rsp1_valid_q | rsp1_ready);
    gnt0  = elig0 & (~elig1 | last_grant_q);
    gnt1  = elig1 & (~elig0 | ~last_grant_q);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    alu_ctrl = CtrlAdd;
    alu_a    = '0;
    alu_b    = '0;
    if (gnt0) begin
      alu_ctrl = req0_ALUinput;
      alu_a    = req0_a;
      alu_b    = req0_b;
    end else if (gnt1) begin
      alu_ctrl = req1_ALUinput;
      alu_a    = req1_a;
      alu_b    = req1_b;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0) begin
      last_grant_d = 1'b0;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
    end
  end

  // A new grant refills the buffer even while it is being drained (back-to-back issue).
  always_comb begin
    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_zero_d   = rsp0_zero_q;
    if (gnt0) begin
      rsp0_valid_d  = 1'b1;
      rsp0_result_d = alu_result;
      rsp0_zero_d   = alu_zero;
    end else if (rsp0_ready) begin
      rsp0_valid_d  = 1'b0;
    end
  end

  always_comb begin
    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_zero_d   = rsp1_zero_q;
    if (gnt1) begin
      rsp1_valid_d  = 1'b1;
      rsp1_result_d = alu_result;
      rsp1_zero_d   = alu_zero;
    end else if (rsp1_ready) begin
      rsp1_valid_d  = 1'b0;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q  <= 1'b1;
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_zero_q   <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_zero_q   <= rsp1_zero_d;
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_zero   = rsp1_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a transaction-level model
// of arbitration, response buffering and the ALU itself.
module tb_alu_share_arbiter;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            v [2];
  logic [3:0]      op [2];
  logic [XLEN-1:0] a [2];
  logic [XLEN-1:0] b [2];
  logic            rr [2];

  logic            req0_ready, req1_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic            alu_zero;
  logic            rsp0_valid, rsp0_zero, rsp1_valid, rsp1_zero;
  logic [XLEN-1:0] rsp0_result, rsp1_result;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic            m_valid [2];
  logic [XLEN-1:0] m_res [2];
  logic            m_zero [2];
  int              m_last;
  int              win;
  int              wait_c [2];
  logic            g_dut [2];

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] c, input logic [XLEN-1:0] x,
                                             input logic [XLEN-1:0] y);
    logic [5:0] sh;
    sh = y[5:0];
    case (c)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return x + y;
      4'd3:    return x ^ y;
      4'd4:    return x << sh;
      4'd5:    return x >> sh;
      4'd6:    return x - y;
      4'd7:    return (x < y) ? 64'd1 : 64'd0;
      4'd8:    return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      4'd9:    return $unsigned($signed(x) >>> sh);
      default: return '0;
    endcase
  endfunction

  // Shared ALU seen by the DUT
  always_comb begin
    alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
    alu_zero   = (alu_result == '0);
  end

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_valid    (v[0]),
    .req0_ready    (req0_ready),
    .req0_ALUinput (op[0]),
    .req0_a        (a[0]),
    .req0_b        (b[0]),
    .req1_valid    (v[1]),
    .req1_ready    (req1_ready),
    .req1_ALUinput (op[1]),
    .req1_a        (a[1]),
    .req1_b        (b[1]),
    .alu_ctrl      (alu_ctrl),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .rsp0_valid    (rsp0_valid),
    .rsp0_ready    (rr[0]),
    .rsp0_result   (rsp0_result),
    .rsp0_zero     (rsp0_zero),
    .rsp1_valid    (rsp1_valid),
    .rsp1_ready    (rr[1]),
    .rsp1_result   (rsp1_result),
    .rsp1_zero     (rsp1_zero)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic new_op(input int i);
    op[i] = 4'($urandom_range(0, 9));
    a[i]  = {$urandom, $urandom};
    b[i]  = ($urandom_range(0, 3) == 0) ? a[i] : {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) b[i] = XLEN'($urandom_range(0, 70));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_res[i]   = '0;
      m_zero[i]  = 1'b0;
      wait_c[i]  = 0;
    end
    m_last = 1;
  endtask

  // Called shortly after a rising edge; checks the cycle, then advances past the next edge.
  task automatic cycle();
    logic e [2];
    logic [XLEN-1:0] r;
    @(negedge clk);
    for (int i = 0; i < 2; i++) e[i] = v[i] && (!m_valid[i] || rr[i]);
    if (e[0] && e[1])  win = 1 - m_last;
    else if (e[0])     win = 0;
    else if (e[1])     win = 1;
    else               win = -1;
    g_dut[0] = req0_ready;
    g_dut[1] = req1_ready;
    check("req0_ready", XLEN'(req0_ready), XLEN'(win == 0));
    check("req1_ready", XLEN'(req1_ready), XLEN'(win == 1));
    if (win >= 0) begin
      check("alu_ctrl", XLEN'(alu_ctrl), XLEN'(op[win]));
      check("alu_a", alu_a, a[win]);
      check("alu_b", alu_b, b[win]);
    end else begin
      check("alu_ctrl_idle", XLEN'(alu_ctrl), XLEN'(4'b0010));
      check("alu_a_idle", alu_a, '0);
      check("alu_b_idle", alu_b, '0);
    end
    check("rsp0_valid", XLEN'(rsp0_valid), XLEN'(m_valid[0]));
    check("rsp0_result", rsp0_result, m_res[0]);
    check("rsp0_zero", XLEN'(rsp0_zero), XLEN'(m_zero[0]));
    check("rsp1_valid", XLEN'(rsp1_valid), XLEN'(m_valid[1]));
    check("rsp1_result", rsp1_result, m_res[1]);
    check("rsp1_zero", XLEN'(rsp1_zero), XLEN'(m_zero[1]));
    for (int i = 0; i < 2; i++) begin
      if (e[i] && !g_dut[i]) wait_c[i]++;
      else                   wait_c[i] = 0;
      check("no_starve", XLEN'(wait_c[i] > 1), '0);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (win == i) begin
        r          = alu_fn(op[i], a[i], b[i]);
        m_valid[i] = 1'b1;
        m_res[i]   = r;
        m_zero[i]  = (r == '0);
      end else if (rr[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    if (win >= 0) m_last = win;
    #1;
  endtask

  // Asserts reset shortly after a rising edge, checks async effects, releases mid-cycle.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rst_rsp0_valid", XLEN'(rsp0_valid), '0);
    check("rst_rsp1_valid", XLEN'(rsp1_valid), '0);
    check("rst_rsp0_result", rsp0_result, '0);
    check("rst_rsp1_zero", XLEN'(rsp1_zero), '0);
    check("rst_req0_ready", XLEN'(req0_ready), '0);
    check("rst_req1_ready", XLEN'(req1_ready), '0);
    check("rst_alu_ctrl", XLEN'(alu_ctrl), XLEN'(4'b0010));
    check("rst_alu_a", alu_a, '0);
    v[0] = 1'b0;
    v[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt [2];
    logic [XLEN-1:0] held;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; op[i] = '0; a[i] = '0; b[i] = '0; rr[i] = 1'b1;
    end
    model_clear();
    @(posedge clk);
    #1;
    apply_reset();

    // Single add 5+7
    v[0] = 1'b1; op[0] = 4'b0010; a[0] = 5; b[0] = 7;
    cycle();
    check("add_grant", XLEN'(g_dut[0]), 1);
    v[0] = 1'b0;
    check("add_valid", XLEN'(rsp0_valid), 1);
    check("add_result", rsp0_result, 12);
    check("add_zero", XLEN'(rsp0_zero), 0);
    cycle();

    // Contention after reset: sub 9-9 then or F0|0F
    apply_reset();
    v[0] = 1'b1; op[0] = 4'b0110; a[0] = 9;     b[0] = 9;
    v[1] = 1'b1; op[1] = 4'b0001; a[1] = 'hF0; b[1] = 'h0F;
    cycle();
    check("cont_first", XLEN'(g_dut[0]), 1);
    v[0] = 1'b0;
    check("sub_result", rsp0_result, 0);
    check("sub_zero", XLEN'(rsp0_zero), 1);
    cycle();
    check("cont_second", XLEN'(g_dut[1]), 1);
    v[1] = 1'b0;
    check("or_result", rsp1_result, 'hFF);
    cycle();

    // Continuous contention alternates
    cnt[0] = 0; cnt[1] = 0;
    for (int i = 0; i < 2; i++) begin v[i] = 1'b1; new_op(i); end
    for (int k = 0; k < 10; k++) begin
      cycle();
      for (int i = 0; i < 2; i++) if (g_dut[i]) begin cnt[i]++; new_op(i); end
    end
    check("alt_cnt0", XLEN'(cnt[0]), 5);
    check("alt_cnt1", XLEN'(cnt[1]), 5);
    v[0] = 1'b0; v[1] = 1'b0;
    cycle();

    // Backpressure on buffer 1 does not block requester 0
    v[1] = 1'b1; new_op(1); rr[1] = 1'b0;
    cycle();
    new_op(1);
    held = rsp1_result;
    v[0] = 1'b1; new_op(0); rr[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_req1_blocked", XLEN'(g_dut[1]), 0);
      check("bp_req0_granted", XLEN'(g_dut[0]), 1);
      new_op(0);
    end
    check("bp_rsp1_hold", rsp1_result, held);
    check("bp_rsp1_valid", XLEN'(rsp1_valid), 1);
    v[0] = 1'b0; v[1] = 1'b0; rr[1] = 1'b1;
    cycle();

    // Async reset with a buffered response, then first contention goes to requester 0
    v[0] = 1'b1; new_op(0); rr[0] = 1'b0;
    cycle();
    check("pre_rst_valid", XLEN'(rsp0_valid), 1);
    apply_reset();
    rr[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin v[i] = 1'b1; new_op(i); end
    cycle();
    check("post_rst_first", XLEN'(g_dut[0]), 1);
    new_op(0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (g_dut[i] || !v[i]) begin
          v[i] = ($urandom_range(0, 3) != 0);
          new_op(i);
        end
        rr[i] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter XLEN, default 64, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 (primary instruction stream) has an ALU operation.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_ALUinput  input  4  ALU control code for requester 0 (0000 and, 0001 or, 0010 add, 0011 xor, 0100 sll, 0101 srl, 0110 sub, 0111 sltu, 1000 slt, 1001 sra).
REQ-007 req0_a, req0_b  input  XLEN each  operands for requester 0.
REQ-008 req1_valid, req1_ready, req1_ALUinput, req1_a, req1_b  same as REQ-004..007, for requester 1 (duplicate/QED stream).
REQ-009 alu_ctrl  output  4  control code driven to the shared combinational ALU.
REQ-010 alu_a, alu_b  output  XLEN each  operands driven to the shared ALU.
REQ-011 alu_result  input  XLEN  shared ALU result, same cycle as alu_ctrl/alu_a/alu_b.
REQ-012 alu_zero  input  1  shared ALU zero flag.
REQ-013 rsp0_valid  output  1  response buffer 0 holds a result.
REQ-014 rsp0_ready  input  1  requester 0 consumes the response.
REQ-015 rsp0_result  output  XLEN; rsp0_zero  output  1  buffered result and zero flag for requester 0.
REQ-016 rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero  same as REQ-013..015, for requester 1.

Function
REQ-017 Requester i SHALL be eligible when reqi_valid=1 and (rspi_valid=0 or rspi_ready=1).
REQ-018 At most one requester SHALL be granted per cycle; reqi_ready=1 exactly when requester i is granted; combinational from current inputs and state.
REQ-019 Both eligible: grant SHALL go to the requester not equal to last_grant register; only one eligible: grant it.
REQ-020 last_grant SHALL update to the granted index on every grant and hold otherwise.
REQ-021 While granted, alu_ctrl/alu_a/alu_b SHALL equal the granted requester's fields; with no grant, alu_ctrl=0010, alu_a=0, alu_b=0.
REQ-022 On a grant to i, at the next edge rspi_valid SHALL become 1 and rspi_result/rspi_zero SHALL capture alu_result/alu_zero (latency 1 cycle from accept to response).
REQ-023 rspi_valid=1, rspi_ready=1, no new grant to i: rspi_valid SHALL clear next edge; result/zero hold last value.
REQ-024 rspi_valid=1, rspi_ready=1 and new grant to i same cycle: rspi_valid SHALL stay 1 with new data (back-to-back throughput 1/cycle per requester).
REQ-025 rspi_valid=1, rspi_ready=0: buffer SHALL hold; requester i SHALL NOT be granted (backpressure).
REQ-026 Response buffers SHALL be independent; stall on one SHALL NOT block grants to the other.
REQ-027 A requester continuously eligible SHALL be granted within 2 cycles (no starvation).
REQ-028 Requesters SHALL hold reqi fields stable and valid high until reqi_ready; the bench SHALL flag violations.

Reset
REQ-029 rst_n=0 SHALL asynchronously force rsp0_valid=rsp1_valid=0, rsp0_result=rsp1_result=0, rsp0_zero=rsp1_zero=0, last_grant=1 (requester 0 wins first contention).
REQ-030 While rst_n=0, req0_ready=req1_ready=0 and ALU outputs SHALL take idle values (REQ-021).
REQ-031 Reset asserted mid-operation SHALL discard buffered responses; no response for an operation accepted in the reset cycle.

Verification
REQ-032 Req0 only, ALUinput=0010, a=5, b=7, rsp0_ready=1 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_result=12, rsp0_zero=0.
REQ-033 Both valid after reset, req0 sub 9-9, req1 or 0xF0|0x0F, rsp ready=1 -> cycle 1 grant 0; cycle 2 grant 1; rsp0_result=0 with rsp0_zero=1; rsp1_result=0xFF.
REQ-034 Both valid continuously for 10 cycles, both rsp_ready=1 -> grants alternate 0,1,0,1...; 5 responses each.
REQ-035 rsp1_ready=0 with rsp1_valid=1, both requesting -> req1_ready=0 every cycle; req0 granted every cycle; rsp1 data unchanged.
REQ-036 rst_n pulled low while rsp0_valid=1 -> rsp0_valid=0 immediately (asynchronous); after release, first contention granted to requester 0.
